// File: rtl/array_feeder.sv
`default_nettype none
// ============================================================================
// Module   : array_feeder
// Brief    : Loads one weight tile into the systolic MAC array, then streams
//            row-skewed ifmap vectors into its left edge.
// Options  : FEEDER_REUSE_WEIGHTS_EN - lets a job skip the weight load.
// Revision : 1.0 - initial release
// ============================================================================
module array_feeder #(
    parameter int IFMAP_WIDTH  = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int ARRAY_HEIGHT = 4,
    parameter int ARRAY_WIDTH  = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [15:0]                         num_vectors,
    input  logic                                keep_weights,
    output logic                                busy,
    output logic                                done,
    input  logic                                w_valid,
    output logic                                w_ready,
    input  logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0] w_data,
    input  logic                                i_valid,
    output logic                                i_ready,
    input  logic [ARRAY_HEIGHT*IFMAP_WIDTH-1:0] i_data,
    output logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0] weight_out,
    output logic                                weight_write_enable,
    output logic [ARRAY_HEIGHT*IFMAP_WIDTH-1:0] ifmap_out,
    output logic [ARRAY_HEIGHT-1:0]             enable_out
);

    localparam int                 c_CNT_W    = $clog2(ARRAY_HEIGHT + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_ROW = c_CNT_W'(ARRAY_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [15:0]         r_num;
    logic [15:0]         r_icnt;
    logic [c_CNT_W-1:0]  r_wcnt;
    logic [c_CNT_W-1:0]  r_dcnt;
    logic                w_w_acc;
    logic                w_i_acc;
    logic                w_last_w;
    logic                w_last_i;
    logic                w_drain_end;
    logic                w_skip_load;

`ifdef FEEDER_REUSE_WEIGHTS_EN
    assign w_skip_load = keep_weights;
`else
    logic w_unused_keep;
    assign w_unused_keep = keep_weights;
    assign w_skip_load   = 1'b0;
`endif

    // Handshake readies decode straight from the state register.
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign w_ready = (r_state == S_LOAD_W);
    assign i_ready = (r_state == S_STREAM);

    assign w_w_acc     = w_valid & w_ready;
    assign w_i_acc     = i_valid & i_ready;
    assign w_last_w    = w_w_acc && (r_wcnt == c_LAST_ROW);
    // r_icnt is at most num-1 while streaming, so the +1 cannot wrap.
    assign w_last_i    = w_i_acc && ((r_icnt + 16'd1) == r_num);
    // Drain spans H cycles so DONE follows the last lane's final output.
    assign w_drain_end = (r_dcnt == c_LAST_ROW);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (!w_skip_load) begin
                        w_state_nxt = S_LOAD_W;
                    end else if (num_vectors == 16'd0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_STREAM;
                    end
                end
            end
            S_LOAD_W: begin
                if (w_last_w) begin
                    w_state_nxt = (r_num == 16'd0) ? S_DONE : S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_last_i) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_end) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state             <= S_IDLE;
            r_num               <= '0;
            r_icnt              <= '0;
            r_wcnt              <= '0;
            r_dcnt              <= '0;
            weight_out          <= '0;
            weight_write_enable <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && start) begin
                r_num <= num_vectors;
            end
            weight_write_enable <= w_w_acc;
            if (w_w_acc) begin
                weight_out <= w_data;
            end
            r_wcnt <= (r_state == S_LOAD_W) ? (r_wcnt + c_CNT_W'(w_w_acc)) : '0;
            r_icnt <= (r_state == S_STREAM) ? (r_icnt + 16'(w_i_acc))      : '0;
            r_dcnt <= (r_state == S_DRAIN)  ? (r_dcnt + c_CNT_W'(1))       : '0;
        end
    end

    // Lane r is delayed by r+1 registers; bubbles and idle cycles fill with zero/invalid.
    generate
        for (genvar r = 0; r < ARRAY_HEIGHT; r++) begin : g_lane
            logic [IFMAP_WIDTH-1:0] r_data [0:r];
            logic                   r_vld  [0:r];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k <= r; k++) begin
                        r_data[k] <= '0;
                        r_vld[k]  <= 1'b0;
                    end
                end else begin
                    r_data[0] <= w_i_acc ? i_data[r*IFMAP_WIDTH +: IFMAP_WIDTH] : '0;
                    r_vld[0]  <= w_i_acc;
                    for (int k = 1; k <= r; k++) begin
                        r_data[k] <= r_data[k-1];
                        r_vld[k]  <= r_vld[k-1];
                    end
                end
            end

            assign ifmap_out[r*IFMAP_WIDTH +: IFMAP_WIDTH] = r_data[r];
            assign enable_out[r]                           = r_vld[r];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_array_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_array_feeder
// Brief    : Randomised self-checking bench for array_feeder, compared against
//            a job-timeline reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_array_feeder;

    localparam int IW   = 4;
    localparam int WW   = 4;
    localparam int H    = 4;
    localparam int AW   = 4;
    localparam int WROW = AW * WW;
    localparam int IROW = H * IW;
    localparam int VW   = 5 + WROW + IROW + H;
    localparam int MAXK = 256;
`ifdef FEEDER_REUSE_WEIGHTS_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [15:0]     num_vectors;
    logic            keep_weights;
    logic            busy;
    logic            done;
    logic            w_valid;
    logic            w_ready;
    logic [WROW-1:0] w_data;
    logic            i_valid;
    logic            i_ready;
    logic [IROW-1:0] i_data;
    logic [WROW-1:0] weight_out;
    logic            weight_write_enable;
    logic [IROW-1:0] ifmap_out;
    logic [H-1:0]    enable_out;

    array_feeder #(
        .IFMAP_WIDTH (IW),
        .WEIGHT_WIDTH(WW),
        .ARRAY_HEIGHT(H),
        .ARRAY_WIDTH (AW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .num_vectors        (num_vectors),
        .keep_weights       (keep_weights),
        .busy               (busy),
        .done               (done),
        .w_valid            (w_valid),
        .w_ready            (w_ready),
        .w_data             (w_data),
        .i_valid            (i_valid),
        .i_ready            (i_ready),
        .i_data             (i_data),
        .weight_out         (weight_out),
        .weight_write_enable(weight_write_enable),
        .ifmap_out          (ifmap_out),
        .enable_out         (enable_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Stimulus for the edge k cycles after the start edge (k = 0 is the start edge).
    bit              wv [MAXK];
    bit              iv [MAXK];
    logic [WROW-1:0] wd [MAXK];
    logic [IROW-1:0] id [MAXK];

    logic [VW-1:0]   exp_vec  [MAXK];
    logic [VW-1:0]   obs_vec  [MAXK];
    logic            obs_done [MAXK];
    logic            obs_ir   [MAXK];
    logic            obs_wr   [MAXK];
    logic            obs_wwe  [MAXK];
    logic [WROW-1:0] obs_wout [MAXK];
    logic [IROW-1:0] obs_ifm  [MAXK];
    logic [H-1:0]    obs_en   [MAXK];
    int              exp_len;
    int              job_d;
    logic [WROW-1:0] prev_w = '0;

    task automatic rand_stim();
        for (int k = 0; k < MAXK; k++) begin
            wv[k] = (k >= MAXK/2) ? 1'b1 : (($urandom % 4) != 0);
            iv[k] = (k >= MAXK/2) ? 1'b1 : (($urandom % 4) != 0);
            wd[k] = WROW'($urandom);
            id[k] = IROW'($urandom);
        end
    endtask

    // Job timeline: the first H valid weight beats load the tile, the next
    // num valid ifmap beats are streamed, and done lands H edges after the
    // last ifmap accept. Lane r shows the beat accepted r edges earlier.
    task automatic model_job(input int num, input bit keep, input int rst_at);
        bit              wacc [MAXK];
        bit              iacc [MAXK];
        bit              load;
        int              cnt, lw, li, d, j;
        logic [WROW-1:0] wout;
        logic [IROW-1:0] ifm;
        logic [H-1:0]    en;
        for (int k = 0; k < MAXK; k++) begin
            wacc[k] = 1'b0;
            iacc[k] = 1'b0;
        end
        load = !(keep && REUSE);
        lw   = 0;
        li   = 0;
        if (load) begin
            cnt = 0;
            for (int k = 1; k < MAXK; k++) begin
                if (wv[k]) begin
                    wacc[k] = 1'b1;
                    cnt++;
                    if (cnt == H) begin
                        lw = k;
                        break;
                    end
                end
            end
        end
        if (num == 0) begin
            d = lw;
        end else begin
            cnt = 0;
            for (int k = lw + 1; k < MAXK; k++) begin
                if (iv[k]) begin
                    iacc[k] = 1'b1;
                    cnt++;
                    if (cnt == num) begin
                        li = k;
                        break;
                    end
                end
            end
            d = li + H;
        end
        job_d   = d;
        exp_len = (rst_at >= 0) ? rst_at + 3 : d + 3;
        wout    = prev_w;
        for (int k = 0; k < exp_len; k++) begin
            if (rst_at >= 0 && k >= rst_at) begin
                exp_vec[k] = '0;
            end else begin
                if (wacc[k]) wout = wd[k];
                ifm = '0;
                en  = '0;
                for (int r = 0; r < H; r++) begin
                    j = k - r;
                    if (j >= 1 && iacc[j]) begin
                        ifm[r*IW +: IW] = id[j][r*IW +: IW];
                        en[r]           = 1'b1;
                    end
                end
                exp_vec[k] = {(k <= d), (k == d), (load && k < lw),
                              (num != 0 && k >= lw && k < li), wacc[k], wout, ifm, en};
            end
        end
        prev_w = (rst_at >= 0) ? '0 : wout;
    endtask

    // Drives one job from IDLE and records the outputs after every edge.
    // Spurious starts and out-of-phase valids are injected while the job runs.
    task automatic run_job(input int num, input bit keep, input int rst_at);
        int lim;
        model_job(num, keep, rst_at);
        lim          = (rst_at >= 0) ? rst_at - 1 : job_d + 1;
        start        = 1'b1;
        num_vectors  = 16'(num);
        keep_weights = keep;
        rst          = 1'b0;
        w_valid      = wv[0];
        w_data       = wd[0];
        i_valid      = iv[0];
        i_data       = id[0];
        for (int k = 0; k < exp_len; k++) begin
            @(posedge clk);
            #1;
            obs_vec[k]  = {busy, done, w_ready, i_ready, weight_write_enable,
                           weight_out, ifmap_out, enable_out};
            obs_done[k] = done;
            obs_ir[k]   = i_ready;
            obs_wr[k]   = w_ready;
            obs_wwe[k]  = weight_write_enable;
            obs_wout[k] = weight_out;
            obs_ifm[k]  = ifmap_out;
            obs_en[k]   = enable_out;
            start        = (k + 1 <= lim) && (($urandom % 4) == 0);
            num_vectors  = 16'($urandom);
            keep_weights = 1'($urandom);
            rst          = (k + 1 == rst_at);
            if (k + 1 < MAXK) begin
                w_valid = wv[k+1];
                w_data  = wd[k+1];
                i_valid = iv[k+1];
                i_data  = id[k+1];
            end
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        int              idx;
        logic [WROW-1:0] seq  [4];
        logic [WROW-1:0] want [4];
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            total++;
            if ({busy, done, w_ready, i_ready, weight_write_enable, weight_out,
                 ifmap_out, enable_out} !== '0) begin
                bad++;
                $display("FAIL reset_outputs edge=%0d got=%h want=0", i,
                         {busy, done, w_ready, i_ready, weight_write_enable,
                          weight_out, ifmap_out, enable_out});
            end
        end
        rst    = 1'b0;
        prev_w = '0;
        rand_stim();
        want[0] = 16'h4444;
        want[1] = 16'h3333;
        want[2] = 16'h2222;
        want[3] = 16'h1111;
        for (int i = 0; i < 4; i++) begin
            wv[i+1] = 1'b1;
            wd[i+1] = want[i];
        end
        run_job(3, 1'b0, -1);
        for (int k = 0; k < exp_len; k++) begin
            total++;
            if (obs_vec[k] !== exp_vec[k]) begin
                bad++;
                $display("FAIL reset_job_trace k=%0d got=%h want=%h", k, obs_vec[k], exp_vec[k]);
            end
        end
        idx = 0;
        for (int i = 0; i < 4; i++) seq[i] = 'x;
        for (int k = 0; k < exp_len; k++) begin
            if (obs_wwe[k] === 1'b1) begin
                if (idx < 4) seq[idx] = obs_wout[k];
                idx++;
            end
        end
        total++;
        if (idx != 4) begin
            bad++;
            $display("FAIL wwe_cycle_count got=%0d want=4", idx);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (seq[i] !== want[i]) begin
                bad++;
                $display("FAIL weight_order beat=%0d got=%h want=%h", i, seq[i], want[i]);
            end
        end
    endtask

    task automatic test_skew();
        logic [IW-1:0] l0 [3];
        logic [IW-1:0] l3 [3];
        rand_stim();
        for (int i = 1; i <= 4; i++) wv[i] = 1'b1;
        for (int i = 5; i <= 7; i++) iv[i] = 1'b1;
        id[5] = 16'h1234;
        id[6] = 16'h5678;
        id[7] = 16'h9ABC;
        l0[0] = 4'h4; l0[1] = 4'h8; l0[2] = 4'hC;
        l3[0] = 4'h1; l3[1] = 4'h5; l3[2] = 4'h9;
        run_job(3, 1'b0, -1);
        for (int k = 0; k < exp_len; k++) begin
            total++;
            if (obs_vec[k] !== exp_vec[k]) begin
                bad++;
                $display("FAIL skew_trace k=%0d got=%h want=%h", k, obs_vec[k], exp_vec[k]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({obs_en[5+i][0], obs_ifm[5+i][IW-1:0]} !== {1'b1, l0[i]}) begin
                bad++;
                $display("FAIL skew_lane0 beat=%0d got=%h want=%h", i,
                         {obs_en[5+i][0], obs_ifm[5+i][IW-1:0]}, {1'b1, l0[i]});
            end
            total++;
            if ({obs_en[8+i][3], obs_ifm[8+i][3*IW +: IW]} !== {1'b1, l3[i]}) begin
                bad++;
                $display("FAIL skew_lane3 beat=%0d got=%h want=%h", i,
                         {obs_en[8+i][3], obs_ifm[8+i][3*IW +: IW]}, {1'b1, l3[i]});
            end
        end
        total++;
        if (obs_done[11] !== 1'b1) begin
            bad++;
            $display("FAIL skew_done_time got=%b want=1", obs_done[11]);
        end
    endtask

    task automatic test_bubbles();
        rand_stim();
        for (int i = 1; i <= 4; i++) wv[i] = 1'b1;
        iv[5] = 1'b1;
        iv[6] = 1'b0;
        iv[7] = 1'b1;
        id[6] = 16'hFFFF;
        run_job(2, 1'b0, -1);
        for (int k = 0; k < exp_len; k++) begin
            total++;
            if (obs_vec[k] !== exp_vec[k]) begin
                bad++;
                $display("FAIL bubble_trace k=%0d got=%h want=%h", k, obs_vec[k], exp_vec[k]);
            end
        end
        for (int r = 0; r < H; r++) begin
            total++;
            if ({obs_en[6+r][r], obs_ifm[6+r][r*IW +: IW]} !== '0) begin
                bad++;
                $display("FAIL bubble_gap lane=%0d got=%h want=0", r,
                         {obs_en[6+r][r], obs_ifm[6+r][r*IW +: IW]});
            end
        end
        total++;
        if ({obs_done[10], obs_done[11]} !== 2'b01) begin
            bad++;
            $display("FAIL bubble_done_time got=%b want=01", {obs_done[10], obs_done[11]});
        end
    endtask

    task automatic test_zero_vectors();
        int nir;
        rand_stim();
        for (int i = 1; i <= 4; i++) wv[i] = 1'b1;
        run_job(0, 1'b0, -1);
        nir = 0;
        for (int k = 0; k < exp_len; k++) begin
            total++;
            if (obs_vec[k] !== exp_vec[k]) begin
                bad++;
                $display("FAIL zero_trace k=%0d got=%h want=%h", k, obs_vec[k], exp_vec[k]);
            end
            if (obs_ir[k] !== 1'b0) nir++;
        end
        total++;
        if (nir != 0) begin
            bad++;
            $display("FAIL zero_i_ready cycles_high got=%0d want=0", nir);
        end
        total++;
        if (obs_done[4] !== 1'b1) begin
            bad++;
            $display("FAIL zero_done_time got=%b want=1", obs_done[4]);
        end
    endtask

    task automatic test_reset_mid();
        int ndone;
        rand_stim();
        for (int i = 1; i <= 4; i++) wv[i] = 1'b1;
        for (int i = 5; i <= 9; i++) iv[i] = 1'b1;
        run_job(5, 1'b0, 7);
        ndone = 0;
        for (int k = 0; k < exp_len; k++) begin
            total++;
            if (obs_vec[k] !== exp_vec[k]) begin
                bad++;
                $display("FAIL midrst_trace k=%0d got=%h want=%h", k, obs_vec[k], exp_vec[k]);
            end
            if (obs_done[k] !== 1'b0) ndone++;
        end
        total++;
        if (obs_vec[7] !== '0) begin
            bad++;
            $display("FAIL midrst_cleared got=%h want=0", obs_vec[7]);
        end
        total++;
        if (ndone != 0) begin
            bad++;
            $display("FAIL midrst_no_done got=%0d want=0", ndone);
        end
        rand_stim();
        run_job(1 + int'($urandom % 6), 1'b0, -1);
        for (int k = 0; k < exp_len; k++) begin
            total++;
            if (obs_vec[k] !== exp_vec[k]) begin
                bad++;
                $display("FAIL midrst_rejob_trace k=%0d got=%h want=%h", k, obs_vec[k], exp_vec[k]);
            end
        end
    endtask

    task automatic test_weight_reuse();
        int nwr;
        rand_stim();
        run_job(3, 1'b1, -1);
        nwr = 0;
        for (int k = 0; k < exp_len; k++) begin
            total++;
            if (obs_vec[k] !== exp_vec[k]) begin
                bad++;
                $display("FAIL reuse_trace k=%0d got=%h want=%h", k, obs_vec[k], exp_vec[k]);
            end
            if (obs_wr[k] === 1'b1) nwr++;
        end
`ifdef FEEDER_REUSE_WEIGHTS_EN
        total++;
        if (nwr != 0 || obs_ir[0] !== 1'b1) begin
            bad++;
            $display("FAIL reuse_skip_load w_ready_cycles=%0d i_ready0=%b want=0/1", nwr, obs_ir[0]);
        end
`else
        total++;
        if (nwr == 0 || obs_wr[0] !== 1'b1) begin
            bad++;
            $display("FAIL reuse_ignored w_ready_cycles=%0d w_ready0=%b want>0/1", nwr, obs_wr[0]);
        end
`endif
    endtask

    task automatic test_random();
        for (int j = 0; j < 6; j++) begin
            rand_stim();
            run_job(int'($urandom % 13), 1'($urandom), -1);
            for (int k = 0; k < exp_len; k++) begin
                total++;
                if (obs_vec[k] !== exp_vec[k]) begin
                    bad++;
                    $display("FAIL random_trace job=%0d k=%0d got=%h want=%h", j, k, obs_vec[k], exp_vec[k]);
                end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        num_vectors  = '0;
        keep_weights = 1'b0;
        w_valid      = 1'b0;
        w_data       = '0;
        i_valid      = 1'b0;
        i_data       = '0;
        test_reset();
        test_skew();
        test_bubbles();
        test_zero_vectors();
        test_reset_mid();
        test_weight_reuse();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
